mux_4x1_2bit: RTL and testbench
===============================

# mux_4x1_2bit

Registered 2-bit, 4-to-1 multiplexer with two independent implementations of the same selection function: a behavioral path and a gate-level path. Both results are registered, and a registered comparator flags any disagreement between them. The block is a small datapath selector and a self-checking reference for gate-level versus behavioral equivalence in the lab datapath.

## Interface
Parameters:
- none

Ports (reset is synchronous and active-high; one clock):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- a1, a0  in  1 each  input A, bit 1 (MSB) and bit 0
- b1, b0  in  1 each  input B
- c1, c0  in  1 each  input C
- d1, d0  in  1 each  input D
- s1, s0  in  1 each  select, s1 = MSB
- out1_beh, out0_beh  out  1 each  registered behavioral result
- out1_gate, out0_gate  out  1 each  registered gate-level result
- mismatch  out  1  registered: behavioral and gate-level results differed on the last sampled inputs
- mismatch_sticky  out  1  set on any mismatch; held until rst

## Operation
- Selection, per bit i in {1,0}:
  - {s1,s0} = 00 → ai
  - 01 → bi
  - 10 → ci
  - 11 → di
- Behavioral path:
  - case/conditional on {s1,s0}.
  - Select inputs at X/Z: default branch yields 0 for both bits.
- Gate-level path, built only from NOT/AND/OR primitives:
  - outi = (~s1 & ~s0 & ai) | (~s1 & s0 & bi) | (s1 & ~s0 & ci) | (s1 & s0 & di).
  - Inverted selects are shared by both bits.
- Comparator (combinational):
  - neq = (beh1 ≠ gate1) | (beh0 ≠ gate0).
  - Evaluated on the pre-register combinational values.
- Registers, on each rising clk:
  - rst = 1: out1_beh, out0_beh, out1_gate, out0_gate, mismatch and mismatch_sticky all ← 0.
  - Otherwise: outputs ← combinational results; mismatch ← neq; mismatch_sticky ← mismatch_sticky | neq.
- rst has priority over all data. Assertion mid-stream clears the sticky flag and all outputs at that edge.
- No enable. A new sample is taken every cycle.

## Timing
- Latency: 1 cycle. Inputs stable before rising edge N appear on the outputs after edge N.
- Throughput: one selection per cycle.
- No combinational path from any input to any output.
- mismatch aligns with the data outputs it describes (same edge).
- mismatch_sticky rises on the same edge as the first mismatch and stays high until an edge with rst = 1.
- First edge after rst deasserts: outputs reflect the inputs sampled at that edge.

## Structure
- Shared package mux_pkg:
  - select encoding constants SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_D = 2'b11
  - data width constant DW = 2
- Sub-module mux_4x1_2bit_gates: pure combinational gate-level path (primitive instances only), instantiated once in the top.
- Behavioral path, comparator and registers live in the top.

## Test plan
- Reset: drive rst = 1 for 2 cycles with arbitrary inputs → all six outputs are 0 after each edge.
- Fixed data A = 00, B = 01, C = 10, D = 11, sweep {s1,s0} = 00, 01, 10, 11 one per cycle → both output pairs read 00, 01, 10, 11 one cycle after each select; mismatch stays 0.
- Hold select at 10 while toggling c1/c0 through all four values each cycle; toggle a, b, d freely → outputs track C with 1-cycle lag; changes on a, b, d have no effect.
- Exhaustive sweep of all 1024 input combinations, one per cycle → behavioral and gate-level outputs equal the reference selection every cycle; mismatch_sticky stays 0.
- Assert rst mid-sweep for one cycle → outputs 0 on that edge; next edge resumes with correct selection.
- Force a fault in the gate sub-module (bench override: out0 stuck at 1) with select 00, A = 00 → mismatch = 1 one cycle later; mismatch_sticky stays 1 after the fault is removed, until rst.

Source files
------------

// File: rtl/mux_4x1_2bit_pkg.sv
// Shared constants for the 2-bit 4:1 selector.
// Covers the select encoding and the data width.
package mux_pkg;

    localparam int DW = 2;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_4x1_2bit_if.sv
// Signal bundle for the 2-bit 4:1 selector.
// The master drives data and select; the slave returns both result pairs and the mismatch flags.
interface mux_4x1_2bit_if;

    logic a1, a0, b1, b0, c1, c0, d1, d0;
    logic s1, s0;
    logic out1_beh, out0_beh, out1_gate, out0_gate;
    logic mismatch, mismatch_sticky;

    modport master (
        output a1, a0, b1, b0, c1, c0, d1, d0, s1, s0,
        input  out1_beh, out0_beh, out1_gate, out0_gate, mismatch, mismatch_sticky
    );

    modport slave (
        input  a1, a0, b1, b0, c1, c0, d1, d0, s1, s0,
        output out1_beh, out0_beh, out1_gate, out0_gate, mismatch, mismatch_sticky
    );

endinterface

// File: rtl/mux_4x1_2bit_gates.sv
// Gate-level 4:1 selection built from NOT/AND/OR primitives only.
// The inverted selects are shared by every data bit.
module mux_4x1_2bit_gates
    import mux_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] d_i,
    input  logic          s1_i,
    input  logic          s0_i,
    output logic [DW-1:0] out_o
);

    logic s1_n;
    logic s0_n;

    not u_not_s1 (s1_n, s1_i);
    not u_not_s0 (s0_n, s0_i);

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_bit
            logic term_a, term_b, term_c, term_d;

            and u_and_a (term_a, s1_n, s0_n, a_i[gi]);
            and u_and_b (term_b, s1_n, s0_i, b_i[gi]);
            and u_and_c (term_c, s1_i, s0_n, c_i[gi]);
            and u_and_d (term_d, s1_i, s0_i, d_i[gi]);
            or  u_or    (out_o[gi], term_a, term_b, term_c, term_d);
        end
    endgenerate

endmodule

// File: rtl/mux_4x1_2bit.sv
// Registered 2-bit 4:1 selector with behavioural and gate-level paths side by side.
// A registered comparator flags disagreement; the sticky flag holds it until reset.
module mux_4x1_2bit
    import mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a1, a0, b1, b0, c1, c0, d1, d0,
    input  logic s1, s0,
    output logic out1_beh, out0_beh,
    output logic out1_gate, out0_gate,
    output logic mismatch,
    output logic mismatch_sticky
);

    logic [DW-1:0] beh_d, beh_q;
    logic [DW-1:0] gate_c, gate_q;
    logic          neq_c;
    logic          mismatch_q;
    logic          sticky_d, sticky_q;

    mux_4x1_2bit_gates u_gates (
        .a_i   ({a1, a0}),
        .b_i   ({b1, b0}),
        .c_i   ({c1, c0}),
        .d_i   ({d1, d0}),
        .s1_i  (s1),
        .s0_i  (s0),
        .out_o (gate_c)
    );

    // An unknown select falls through to default so the behavioural path reads 0.
    always_comb begin
        beh_d = '0;
        case ({s1, s0})
            SEL_A:   beh_d = {a1, a0};
            SEL_B:   beh_d = {b1, b0};
            SEL_C:   beh_d = {c1, c0};
            SEL_D:   beh_d = {d1, d0};
            default: beh_d = '0;
        endcase
    end

    always_comb begin
        neq_c    = (beh_d[1] != gate_c[1]) | (beh_d[0] != gate_c[0]);
        sticky_d = sticky_q | neq_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beh_q      <= '0;
            gate_q     <= '0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            beh_q      <= beh_d;
            gate_q     <= gate_c;
            mismatch_q <= neq_c;
            sticky_q   <= sticky_d;
        end
    end

    assign out1_beh        = beh_q[1];
    assign out0_beh        = beh_q[0];
    assign out1_gate       = gate_q[1];
    assign out0_gate       = gate_q[0];
    assign mismatch        = mismatch_q;
    assign mismatch_sticky = sticky_q;

endmodule

// File: tb/tb_mux_4x1_2bit.sv
// Bench for mux_4x1_2bit: a selection model checked every cycle, plus literal
// expectations for reset, select sweep, held select, mid-sweep reset and fault injection.
module tb_mux_4x1_2bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_4x1_2bit_if bus ();

    mux_4x1_2bit dut (
        .clk             (clk),
        .rst             (rst),
        .a1              (bus.a1), .a0 (bus.a0),
        .b1              (bus.b1), .b0 (bus.b0),
        .c1              (bus.c1), .c0 (bus.c0),
        .d1              (bus.d1), .d0 (bus.d0),
        .s1              (bus.s1), .s0 (bus.s0),
        .out1_beh        (bus.out1_beh),
        .out0_beh        (bus.out0_beh),
        .out1_gate       (bus.out1_gate),
        .out0_gate       (bus.out0_gate),
        .mismatch        (bus.mismatch),
        .mismatch_sticky (bus.mismatch_sticky)
    );

    int   n_vec = 0;
    int   n_err = 0;
    logic fault_on = 1'b0;
    logic exp_sticky = 1'b0;

    function automatic logic [5:0] dut_vec();
        return {bus.out1_beh, bus.out0_beh, bus.out1_gate, bus.out0_gate,
                bus.mismatch, bus.mismatch_sticky};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got beh/gate/mm/sticky=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pick the word indexed by the select from a table of the four inputs.
    always @(posedge clk) begin
        logic [1:0] words [4];
        logic [1:0] sel, exp_beh, exp_gate;
        logic       exp_mm;
        words[0] = {bus.a1, bus.a0};
        words[1] = {bus.b1, bus.b0};
        words[2] = {bus.c1, bus.c0};
        words[3] = {bus.d1, bus.d0};
        sel      = {bus.s1, bus.s0};
        exp_beh  = words[sel];
        exp_gate = fault_on ? 2'b01 : exp_beh;
        exp_mm   = (exp_beh != exp_gate);
        if (rst) begin
            exp_beh    = 2'b00;
            exp_gate   = 2'b00;
            exp_mm     = 1'b0;
            exp_sticky = 1'b0;
        end else begin
            exp_sticky = exp_sticky | exp_mm;
        end
        #1;
        chk("model", dut_vec(), {exp_beh, exp_gate, exp_mm, exp_sticky});
    end

    task automatic drive(input logic r, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d, input logic [1:0] s);
        @(negedge clk);
        rst    = r;
        bus.a1 = a[1]; bus.a0 = a[0];
        bus.b1 = b[1]; bus.b0 = b[0];
        bus.c1 = c[1]; bus.c0 = c[0];
        bus.d1 = d[1]; bus.d0 = d[0];
        bus.s1 = s[1]; bus.s0 = s[0];
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] sv;
        logic [1:0] cv;
        logic [9:0] v;
        bus.a1 = 1'b1; bus.a0 = 1'b0; bus.b1 = 1'b1; bus.b0 = 1'b1;
        bus.c1 = 1'b0; bus.c0 = 1'b1; bus.d1 = 1'b1; bus.d0 = 1'b0;
        bus.s1 = 1'b0; bus.s0 = 1'b1;

        // Reset held two cycles with nonzero data.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'b11, 2'b10, 2'b01, 2'b11, 2'(k + 1));
            chk("reset", dut_vec(), 6'b000000);
        end

        // Fixed data, select sweep: each result equals the select value.
        for (int k = 0; k < 4; k++) begin
            sv = 2'(k);
            drive(1'b0, 2'b00, 2'b01, 2'b10, 2'b11, sv);
            chk("sel_sweep", dut_vec(), {sv, sv, 2'b00});
        end

        // Select held at C; other inputs random.
        for (int k = 0; k < 8; k++) begin
            cv = 2'(k);
            drive(1'b0, 2'($urandom), 2'($urandom), cv, 2'($urandom), 2'b10);
            chk("hold_c", dut_vec(), {cv, cv, 2'b00});
        end

        // Exhaustive sweep with a one-cycle reset in the middle.
        for (int i = 0; i < 1024; i++) begin
            v = 10'(i);
            if (i == 512) begin
                drive(1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11);
                chk("mid_reset", dut_vec(), 6'b000000);
            end
            drive(1'b0, v[9:8], v[7:6], v[5:4], v[3:2], v[1:0]);
        end
        chk("sweep_sticky", {5'b0, bus.mismatch_sticky}, 6'b0);

        // Gate path out0 stuck at 1 with A selected and A = 00.
        @(negedge clk);
        force dut.gate_c = 2'b01;
        fault_on = 1'b1;
        drive(1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00);
        chk("fault", dut_vec(), 6'b000111);
        @(negedge clk);
        release dut.gate_c;
        fault_on = 1'b0;
        drive(1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11);
        chk("fault_cleared", dut_vec(), 6'b111101);
        drive(1'b0, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00);
        chk("sticky_holds", dut_vec(), 6'b101001);
        drive(1'b1, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00);
        chk("sticky_reset", dut_vec(), 6'b000000);
        drive(1'b0, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01);
        chk("after_reset", dut_vec(), 6'b010100);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
